// File: rtl/shadow_flag_stack.sv
// ---------------------------------------------------------------------------
// shadow_flag_stack
//   Save side of the flag shadow path. On exception entry the live N/Z/C/V
//   flags are pushed into a small LIFO; the top entry is presented inverted
//   to the per-flag registers, which load it on the exception-return cycle
//   (the same cycle the entry is popped). Nested exceptions are supported up
//   to DEPTH levels; overflow/underflow attempts raise sticky error flags.
//
// Parameters
//   DEPTH  number of shadow entries (2..8)
//   PTR_W  occupancy counter width, 2**PTR_W > DEPTH
//
// Ports
//   Clk            system clock, rising edge
//   notClk         complement of Clk (reserved for the dff cell library)
//   notReset       synchronous active-low reset
//   F_N/F_Z/F_C/F_V live flags, true polarity
//   PR_Enter       exception entry: push live flags
//   PR_Ex          exception return: pop (flag registers consume the top)
//   notShadowF_*   inverted top-of-stack flags, 1 when empty
//   Depth          occupancy 0..DEPTH
//   Empty / Full   occupancy status
//   ErrOverflow    sticky: push attempted while full
//   ErrUnderflow   sticky: pop attempted while empty
// ---------------------------------------------------------------------------
module shadow_flag_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 3
) (
    input  logic             Clk,
    input  logic             notClk,
    input  logic             notReset,
    input  logic             F_N,
    input  logic             F_Z,
    input  logic             F_C,
    input  logic             F_V,
    input  logic             PR_Enter,
    input  logic             PR_Ex,
    output logic             notShadowF_N,
    output logic             notShadowF_Z,
    output logic             notShadowF_C,
    output logic             notShadowF_V,
    output logic [PTR_W-1:0] Depth,
    output logic             Empty,
    output logic             Full,
    output logic             ErrOverflow,
    output logic             ErrUnderflow
);

    localparam logic [PTR_W-1:0] DEPTH_MAX = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ONE       = PTR_W'(1);

    // Entries are packed {N,Z,C,V}.
    logic [3:0]       entry [DEPTH];
    logic [PTR_W-1:0] depth_q;
    logic [PTR_W-1:0] depth_d;
    logic             ovf_q;
    logic             unf_q;

    logic             is_empty;
    logic             is_full;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [3:0]       wr_data;
    logic             set_ovf;
    logic             set_unf;
    logic [3:0]       top;

    // notClk only clocks the external dff cells; it carries no logic here.
    logic unused_notclk;
    assign unused_notclk = notClk;

    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == DEPTH_MAX);
    assign wr_data  = {F_N, F_Z, F_C, F_V};

    // Operation decode: next depth, entry write enable/index, error sets.
    always_comb begin
        depth_d = depth_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (PR_Enter && PR_Ex) begin
            // Swap: the old top is consumed this cycle and replaced in place.
            // With nothing to consume it degrades to a plain push.
            wr_en = 1'b1;
            if (is_empty) begin
                wr_idx  = '0;
                depth_d = ONE;
                set_unf = 1'b1;
            end else begin
                wr_idx = depth_q - ONE;
            end
        end else if (PR_Enter) begin
            if (is_full) begin
                set_ovf = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_idx  = depth_q;
                depth_d = depth_q + ONE;
            end
        end else if (PR_Ex) begin
            if (is_empty) begin
                set_unf = 1'b1;
            end else begin
                depth_d = depth_q - ONE;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!notReset) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else begin
            depth_q <= depth_d;
            if (set_ovf) ovf_q <= 1'b1;
            if (set_unf) unf_q <= 1'b1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_en && (wr_idx == PTR_W'(i))) begin
                    entry[i] <= wr_data;
                end
            end
        end
    end

    // Top-of-stack select: entry[depth-1], zero when empty.
    always_comb begin
        top = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (depth_q == PTR_W'(i + 1)) begin
                top = entry[i];
            end
        end
    end

    assign {notShadowF_N, notShadowF_Z, notShadowF_C, notShadowF_V} =
        is_empty ? 4'b1111 : ~top;

    assign Depth        = depth_q;
    assign Empty        = is_empty;
    assign Full         = is_full;
    assign ErrOverflow  = ovf_q;
    assign ErrUnderflow = unf_q;

endmodule

// File: tb/tb_shadow_flag_stack.sv
// ---------------------------------------------------------------------------
// tb_shadow_flag_stack
//   Self-checking bench for shadow_flag_stack (DEPTH=4, PTR_W=3). Each driven
//   operation updates a behavioural stack model and queues the expected
//   post-edge view; after the edge the entry is popped and compared.
// ---------------------------------------------------------------------------
module tb_shadow_flag_stack;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 3;

    logic             Clk = 1'b0;
    logic             notClk;
    logic             notReset = 1'b0;
    logic             F_N = 1'b0, F_Z = 1'b0, F_C = 1'b0, F_V = 1'b0;
    logic             PR_Enter = 1'b0, PR_Ex = 1'b0;
    logic             notShadowF_N, notShadowF_Z, notShadowF_C, notShadowF_V;
    logic [PTR_W-1:0] Depth;
    logic             Empty, Full, ErrOverflow, ErrUnderflow;

    assign notClk = ~Clk;
    always #5 Clk = ~Clk;

    shadow_flag_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .Clk          (Clk),
        .notClk       (notClk),
        .notReset     (notReset),
        .F_N          (F_N),
        .F_Z          (F_Z),
        .F_C          (F_C),
        .F_V          (F_V),
        .PR_Enter     (PR_Enter),
        .PR_Ex        (PR_Ex),
        .notShadowF_N (notShadowF_N),
        .notShadowF_Z (notShadowF_Z),
        .notShadowF_C (notShadowF_C),
        .notShadowF_V (notShadowF_V),
        .Depth        (Depth),
        .Empty        (Empty),
        .Full         (Full),
        .ErrOverflow  (ErrOverflow),
        .ErrUnderflow (ErrUnderflow)
    );

    typedef struct {
        logic [3:0] ns;
        int         depth;
        logic       empty;
        logic       full;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural reference stack.
    logic [3:0] m_stack [DEPTH];
    int         m_depth = 0;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] dut_ns();
        return {notShadowF_N, notShadowF_Z, notShadowF_C, notShadowF_V};
    endfunction

    function automatic logic [3:0] model_ns();
        return (m_depth == 0) ? 4'b1111 : ~m_stack[m_depth-1];
    endfunction

    task automatic model_step(input logic rst, input logic en, input logic ex, input logic [3:0] f);
        if (rst) begin
            m_depth = 0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_stack[i] = 4'h0;
        end else if (en && ex) begin
            if (m_depth == 0) begin
                m_stack[0] = f;
                m_depth    = 1;
                m_unf      = 1'b1;
            end else begin
                m_stack[m_depth-1] = f;
            end
        end else if (en) begin
            if (m_depth == DEPTH) m_ovf = 1'b1;
            else begin
                m_stack[m_depth] = f;
                m_depth++;
            end
        end else if (ex) begin
            if (m_depth == 0) m_unf = 1'b1;
            else m_depth--;
        end
    endtask

    task automatic compare_top();
        exp_t e;
        check_eq("sb_size", sb.size(), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check_eq("depth",    32'(Depth),   e.depth);
        check_eq("notShadow", dut_ns(),    e.ns);
        check_eq("empty",    Empty,        e.empty);
        check_eq("full",     Full,         e.full);
        check_eq("ovf",      ErrOverflow,  e.ovf);
        check_eq("unf",      ErrUnderflow, e.unf);
    endtask

    // Called at a falling edge: drive, queue expectation, cross the rising
    // edge, compare, return at the next falling edge.
    task automatic op(input logic rst, input logic en, input logic ex, input logic [3:0] f);
        exp_t e;
        notReset = ~rst;
        PR_Enter = en;
        PR_Ex    = ex;
        {F_N, F_Z, F_C, F_V} = f;
        model_step(rst, en, ex, f);
        e.ns    = model_ns();
        e.depth = m_depth;
        e.empty = (m_depth == 0);
        e.full  = (m_depth == DEPTH);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        compare_top();
        @(negedge Clk);
        notReset = 1'b1;
        PR_Enter = 1'b0;
        PR_Ex    = 1'b0;
    endtask

    task automatic push(input logic [3:0] f);
        op(1'b0, 1'b1, 1'b0, f);
    endtask

    task automatic pop();
        op(1'b0, 1'b0, 1'b1, 4'h0);
    endtask

    task automatic do_reset();
        op(1'b1, 1'b0, 1'b0, 4'h0);
        op(1'b1, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic [3:0] seq5 [5];
        seq5[0] = 4'b0001; seq5[1] = 4'b0010; seq5[2] = 4'b0100;
        seq5[3] = 4'b1000; seq5[4] = 4'b1111;

        @(negedge Clk);

        // Reset after earlier pushes.
        do_reset();
        push(4'b0110);
        push(4'b1011);
        do_reset();
        check_eq("rst_ns", dut_ns(), 4'b1111);
        check_eq("rst_depth", 32'(Depth), 0);

        // Push two, pop two.
        push(4'b1010);
        push(4'b0101);
        check_eq("p2_ns", dut_ns(), 4'b1010);
        pop();
        check_eq("pop1_ns", dut_ns(), 4'b0101);
        pop();
        check_eq("pop2_ns", dut_ns(), 4'b1111);

        // Overflow saturation.
        for (int i = 0; i < 5; i++) push(seq5[i]);
        check_eq("ovf_ns", dut_ns(), 4'b0111);
        check_eq("ovf_full", Full, 1'b1);
        check_eq("ovf_flag", ErrOverflow, 1'b1);

        // Swap from depth 2.
        do_reset();
        push(4'b0000);
        push(4'b1100);
        check_eq("swap_pre_ns", dut_ns(), 4'b0011);
        op(1'b0, 1'b1, 1'b1, 4'b0011);
        check_eq("swap_ns", dut_ns(), 4'b1100);
        check_eq("swap_depth", 32'(Depth), 2);

        // Underflow, then a legal push.
        pop();
        pop();
        pop();
        check_eq("unf_flag", ErrUnderflow, 1'b1);
        push(4'b1001);
        check_eq("unf_push_ns", dut_ns(), 4'b0110);
        check_eq("unf_sticky", ErrUnderflow, 1'b1);

        // Swap while empty acts as push plus underflow; swap while full no overflow.
        do_reset();
        op(1'b0, 1'b1, 1'b1, 4'b0110);
        check_eq("swap_empty_depth", 32'(Depth), 1);
        push(4'b0001); push(4'b0010); push(4'b0011);
        op(1'b0, 1'b1, 1'b1, 4'b1110);
        check_eq("swap_full_ovf", ErrOverflow, 1'b0);
        check_eq("swap_full_ns", dut_ns(), 4'b0001);

        // Reset wins over a coincident push.
        do_reset();
        push(4'b1111); push(4'b1110); push(4'b1101);
        op(1'b1, 1'b1, 1'b0, 4'b1011);
        check_eq("rst_push_depth", 32'(Depth), 0);
        check_eq("rst_push_ns", dut_ns(), 4'b1111);

        // Random mix of operations.
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            op(r < 2, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               4'($urandom_range(0, 15)));
        end

        check_eq("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
